// File: rtl/vx_tb_boot_sequencer.sv
// Vortex bring-up sequencer: orders reset release across the memory, cache and core
// domains, kicks the memory loader, and issues the startup DCR writes before core start.

package VX_gpu_pkg;
  localparam int VX_DCR_ADDR_WIDTH = 12;
  localparam int VX_DCR_DATA_WIDTH = 32;
endpackage

module vx_tb_boot_sequencer
  import VX_gpu_pkg::*;
#(
  parameter int RESET_HOLD         = 8,
  parameter int CACHE_RESET_CYCLES = 4,
  parameter int NUM_DCR            = 3,
  parameter int LOAD_TIMEOUT       = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic                                   mem_loader_done,
  input  logic                                   mem_load_seq_done,
  input  logic [NUM_DCR*VX_DCR_ADDR_WIDTH-1:0]   dcr_tbl_addr,
  input  logic [NUM_DCR*VX_DCR_DATA_WIDTH-1:0]   dcr_tbl_data,
  output logic                                   mem_reset,
  output logic                                   mem_arb_reset,
  output logic                                   mem_load_reset,
  output logic                                   icache_reset,
  output logic                                   dcache_reset,
  output logic                                   gbar_reset,
  output logic                                   core_reset,
  output logic                                   start_mem_loader,
  output logic                                   load_mem,
  output logic                                   dcr_write_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0]           dcr_write_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0]           dcr_write_data,
  output logic                                   boot_done,
  output logic                                   boot_error,
  output logic [2:0]                             state
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int CW = $clog2(CACHE_RESET_CYCLES + 1);
  localparam int LW = $clog2(LOAD_TIMEOUT + 1);
  localparam int IW = $clog2(NUM_DCR + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLD      = 3'd1,
    S_REL_MEM   = 3'd2,
    S_LOAD      = 3'd3,
    S_REL_CACHE = 3'd4,
    S_DCR       = 3'd5,
    S_RUN       = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t                       state_q, state_d;
  logic   [HW-1:0]              hold_cnt;
  logic   [CW-1:0]              cache_cnt;
  logic   [LW-1:0]              load_cnt;
  logic   [IW-1:0]              dcr_idx, dcr_idx_d;
  logic                         loader_flag, seq_flag;
  logic   [VX_DCR_ADDR_WIDTH-1:0] sel_addr;
  logic   [VX_DCR_DATA_WIDTH-1:0] sel_data;

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_HOLD;
      S_HOLD:      if (hold_cnt == HW'(RESET_HOLD - 1)) state_d = S_REL_MEM;
      S_REL_MEM:   state_d = S_LOAD;
      // Completion is checked first so it beats a timeout in the same cycle.
      S_LOAD: begin
        if (loader_flag && seq_flag)                    state_d = S_REL_CACHE;
        else if (load_cnt == LW'(LOAD_TIMEOUT - 1))     state_d = S_ERROR;
      end
      S_REL_CACHE: if (cache_cnt == CW'(CACHE_RESET_CYCLES - 1)) state_d = S_DCR;
      S_DCR:       if (dcr_idx == IW'(NUM_DCR - 1)) state_d = S_RUN;
      S_RUN,
      S_ERROR:     if (start) state_d = S_HOLD;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_reset        = 1'b1;
    mem_arb_reset    = 1'b1;
    mem_load_reset   = 1'b1;
    icache_reset     = 1'b1;
    dcache_reset     = 1'b1;
    gbar_reset       = 1'b1;
    core_reset       = 1'b1;
    start_mem_loader = 1'b0;
    load_mem         = 1'b0;
    boot_done        = 1'b0;
    boot_error       = 1'b0;
    case (state_q)
      S_REL_MEM, S_LOAD, S_REL_CACHE, S_ERROR: begin
        mem_reset      = 1'b0;
        mem_arb_reset  = 1'b0;
        mem_load_reset = 1'b0;
      end
      S_DCR, S_RUN: begin
        mem_reset      = 1'b0;
        mem_arb_reset  = 1'b0;
        mem_load_reset = 1'b0;
        icache_reset   = 1'b0;
        dcache_reset   = 1'b0;
        gbar_reset     = 1'b0;
      end
      default: ;
    endcase
    if (state_q == S_REL_MEM) start_mem_loader = 1'b1;
    if (state_q == S_LOAD)    load_mem         = 1'b1;
    if (state_q == S_RUN) begin
      core_reset = 1'b0;
      boot_done  = 1'b1;
    end
    if (state_q == S_ERROR)   boot_error       = 1'b1;
  end

  // The DCR strobe is registered, so the entry is picked from the index of the next cycle.
  always_comb begin
    dcr_idx_d = (state_q == S_DCR) ? dcr_idx + IW'(1) : '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_DCR; i++) begin
      if (dcr_idx_d == IW'(i)) begin
        sel_addr = dcr_tbl_addr[i*VX_DCR_ADDR_WIDTH +: VX_DCR_ADDR_WIDTH];
        sel_data = dcr_tbl_data[i*VX_DCR_DATA_WIDTH +: VX_DCR_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      hold_cnt        <= '0;
      cache_cnt       <= '0;
      load_cnt        <= '0;
      dcr_idx         <= '0;
      loader_flag     <= 1'b0;
      seq_flag        <= 1'b0;
      dcr_write_valid <= 1'b0;
      dcr_write_addr  <= '0;
      dcr_write_data  <= '0;
    end else begin
      state_q   <= state_d;
      hold_cnt  <= (state_q == S_HOLD && state_d == S_HOLD) ? hold_cnt + HW'(1) : '0;
      cache_cnt <= (state_q == S_REL_CACHE && state_d == S_REL_CACHE) ? cache_cnt + CW'(1) : '0;
      load_cnt  <= (state_q == S_LOAD && state_d == S_LOAD) ? load_cnt + LW'(1) : '0;
      dcr_idx   <= (state_d == S_DCR) ? dcr_idx_d : '0;
      if (state_d == S_HOLD) begin
        loader_flag <= 1'b0;
        seq_flag    <= 1'b0;
      end else if (state_q == S_REL_MEM || state_q == S_LOAD) begin
        loader_flag <= loader_flag | mem_loader_done;
        seq_flag    <= seq_flag | mem_load_seq_done;
      end
      dcr_write_valid <= (state_d == S_DCR);
      dcr_write_addr  <= (state_d == S_DCR) ? sel_addr : '0;
      dcr_write_data  <= (state_d == S_DCR) ? sel_data : '0;
    end
  end

endmodule
